uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

- Receive-side buffer of the UART, directly downstream of the receiver and upstream of the host-facing `Data_Out`/`Pop_Data` port.
- Stores each received character together with its 3-bit receive error status.
- Presents one popped entry on a registered output.
- Raises `FIFO_Full` at half-full plus one, drives `RTS` flow control from that flag, and flags dropped writes on a sticky `FIFO_Overflow`.

## Interface

Parameters:

- `DATA_BITS`, 8, character width.
- `FIFO_WIDTH`, 8, address width. Depth `FIFO_ENTRIES = 2**FIFO_WIDTH`. Full threshold `FULL_LEVEL = FIFO_ENTRIES/2 + 1`.

Ports:

- `Clk` in 1: the one clock; all state updates on its rising edge.
- `Rst` in 1: reset, synchronous, active-high.
- `Push` in 1: receiver strobe, one cycle per received character.
- `Push_Data` in `DATA_BITS`: received character.
- `Push_Error` in 3: receiver status; [0] break, [1] parity, [2] frame.
- `Pop_Data` in 1: host request to load the next entry onto the outputs.
- `Overflow_Clr` in 1: clears `FIFO_Overflow`.
- `Data_Out` out `DATA_BITS`: last popped character.
- `Rx_Error` out 3: error status of the last popped character.
- `Data_Rdy` out 1: equals `!FIFO_Empty`.
- `FIFO_Empty` out 1: `Count == 0`.
- `FIFO_Full` out 1: `Count >= FULL_LEVEL`.
- `FIFO_Overflow` out 1: sticky; set when a push is dropped.
- `Count` out `FIFO_WIDTH+1`: current occupancy, 0..`FIFO_ENTRIES`.
- `RTS` out 1: equals `!FIFO_Full`.

## Operation

Storage and pointers:

- Circular RAM of `FIFO_ENTRIES` words, each `DATA_BITS+3` wide ({error, data}).
- `FIFO_WIDTH`-bit write and read pointers; both wrap from `FIFO_ENTRIES-1` to 0.
- `Count` register is `FIFO_WIDTH+1` bits.

Push is accepted when `Push` is high and either:

- `Count < FIFO_ENTRIES`, or
- `Count == FIFO_ENTRIES` and an accepted pop occurs in the same cycle.

An accepted push writes {`Push_Error`, `Push_Data`} at the write pointer and increments the write pointer.

Pop is accepted when `Pop_Data` is high and `Count > 0`:

- The head entry is loaded into the `Data_Out`/`Rx_Error` registers and the read pointer increments.
- A pop while empty is ignored. `Data_Out` and `Rx_Error` hold their values and the pointers do not move.

Count update:

- +1 on push only.
- −1 on pop only.
- Unchanged when both are accepted or when neither is.

Overflow:

- A push while `Count == FIFO_ENTRIES` with no accepted pop is dropped. Contents are unchanged and `FIFO_Overflow` is set.
- `FIFO_Overflow` clears only on `Overflow_Clr` or `Rst`. If a drop and `Overflow_Clr` occur in the same cycle, set wins.

Empty with simultaneous `Push` and `Pop_Data`:

- The push is accepted; the pop is ignored.
- No write-through to `Data_Out`.

Reset (including mid-operation):

- Pointers and `Count` are set to 0 and all stored entries are discarded; RAM contents need not be cleared.
- Output values after reset: `Data_Out=0`, `Rx_Error=0`, `FIFO_Empty=1`, `Data_Rdy=0`, `FIFO_Full=0`, `FIFO_Overflow=0`, `Count=0`, `RTS=1`.
- `Rst` takes priority over `Push`, `Pop_Data` and `Overflow_Clr` in the same cycle.

## Timing

- `Push` sampled at edge N:
  - `Count`, `FIFO_Empty`, `Data_Rdy`, `FIFO_Full`, `RTS` and `FIFO_Overflow` reflect the push after edge N.
  - All flags are registered or derived only from registered `Count`; none depends combinationally on an input.
- `Pop_Data` sampled at edge N: new `Data_Out`/`Rx_Error` are valid after edge N and held until the next accepted pop.
- A pop directly after an accepted push (push at edge N, pop at edge N+1) returns that entry when the FIFO was previously empty. Minimum push-to-readable latency is 1 cycle.
- Back-to-back pushes and pops are supported every cycle; there are no dead cycles.
- `RTS` falls after the edge at which `Count` reaches `FULL_LEVEL`. It rises after the edge at which `Count` drops to `FULL_LEVEL-1`.

## Test plan

All scenarios use `FIFO_WIDTH=3` (8 entries, `FULL_LEVEL=5`) and `DATA_BITS=8`.

1. Reset, then push 0x3C with error 3'b000, then pop. `Data_Out=0x3C` and `Rx_Error=0` one cycle after the pop. `FIFO_Empty`: 1 → 0 → 1.
2. Push 0x00..0x07. `FIFO_Full` and `RTS=0` appear after the 5th push; `Count=8` after the 8th; `FIFO_Overflow=0`. Pop all 8: data returns in order 0x00..0x07 and `RTS` returns to 1 when `Count=4`.
3. Fill to 8, then push 0xFF. `Count` stays 8, `FIFO_Overflow=1`, and 0xFF is never popped. `Overflow_Clr` gives `FIFO_Overflow=0` on the next cycle.
4. With `Count=8`, assert `Push` (0xAB) and `Pop_Data` together. `Data_Out` equals the old head, `Count` stays 8 and no overflow is flagged. 0xAB is popped last.
5. Push 0xAA with error 3'b010, then 0x00 with 3'b001. Two pops return `Rx_Error` 3'b010 then 3'b001. A third pop while empty leaves `Data_Out=0x00` and `Rx_Error=3'b001`.
6. Push 6 entries 0x10..0x15, pop 2, then assert `Rst`. The next cycle shows all reset values. A subsequent push/pop of 0x5A returns 0x5A, proving the pointers restarted.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: stores {error, character} words and presents the popped head on registered outputs.
// Latency: a push is readable one cycle later; popped data is valid after the pop edge.
// Backpressure: RTS drops once Count reaches FULL_LEVEL; pushes into a full buffer are dropped and flagged.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_WIDTH = 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Push,
    input  logic [DATA_BITS-1:0]  Push_Data,
    input  logic [2:0]            Push_Error,
    input  logic                  Pop_Data,
    input  logic                  Overflow_Clr,
    output logic [DATA_BITS-1:0]  Data_Out,
    output logic [2:0]            Rx_Error,
    output logic                  Data_Rdy,
    output logic                  FIFO_Empty,
    output logic                  FIFO_Full,
    output logic                  FIFO_Overflow,
    output logic [FIFO_WIDTH:0]   Count,
    output logic                  RTS
);

    localparam int FIFO_ENTRIES = 2**FIFO_WIDTH;
    localparam int FULL_LEVEL   = FIFO_ENTRIES/2 + 1;

    localparam logic [FIFO_WIDTH:0] CNT_MAX  = (FIFO_WIDTH+1)'(FIFO_ENTRIES);
    localparam logic [FIFO_WIDTH:0] CNT_FULL = (FIFO_WIDTH+1)'(FULL_LEVEL);

    logic [DATA_BITS+2:0]  mem [FIFO_ENTRIES];
    logic [FIFO_WIDTH-1:0] wr_ptr;
    logic [FIFO_WIDTH-1:0] rd_ptr;
    logic                  pop_ok;
    logic                  push_ok;
    logic                  push_drop;

    // A full buffer still accepts a push when a pop frees the head slot in the same cycle.
    assign pop_ok    = Pop_Data && (Count != '0);
    assign push_ok   = Push && ((Count < CNT_MAX) || pop_ok);
    assign push_drop = Push && !push_ok;

    assign FIFO_Empty = (Count == '0);
    assign Data_Rdy   = !FIFO_Empty;
    assign FIFO_Full  = (Count >= CNT_FULL);
    assign RTS        = !FIFO_Full;

    always_ff @(posedge Clk) begin
        if (!Rst && push_ok) begin
            mem[wr_ptr] <= {Push_Error, Push_Data};
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            Count         <= '0;
            Data_Out      <= '0;
            Rx_Error      <= '0;
            FIFO_Overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                {Rx_Error, Data_Out} <= mem[rd_ptr];
                rd_ptr               <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                Count <= Count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                Count <= Count - 1'b1;
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (push_drop) begin
                FIFO_Overflow <= 1'b1;
            end else if (Overflow_Clr) begin
                FIFO_Overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with 8 entries (FULL_LEVEL = 5): table vectors plus hand sequences.
module tb_uart_rx_fifo;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Push = 1'b0;
    logic [7:0] Push_Data = 8'h00;
    logic [2:0] Push_Error = 3'b000;
    logic       Pop_Data = 1'b0;
    logic       Overflow_Clr = 1'b0;
    logic [7:0] Data_Out;
    logic [2:0] Rx_Error;
    logic       Data_Rdy;
    logic       FIFO_Empty;
    logic       FIFO_Full;
    logic       FIFO_Overflow;
    logic [3:0] Count;
    logic       RTS;

    uart_rx_fifo #(.DATA_BITS(8), .FIFO_WIDTH(3)) dut (
        .Clk(Clk), .Rst(Rst), .Push(Push), .Push_Data(Push_Data), .Push_Error(Push_Error),
        .Pop_Data(Pop_Data), .Overflow_Clr(Overflow_Clr), .Data_Out(Data_Out), .Rx_Error(Rx_Error),
        .Data_Rdy(Data_Rdy), .FIFO_Empty(FIFO_Empty), .FIFO_Full(FIFO_Full),
        .FIFO_Overflow(FIFO_Overflow), .Count(Count), .RTS(RTS)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       rst, push, pop, clr;
        logic [7:0] din;
        logic [2:0] ein;
        logic [7:0] dout;
        logic [2:0] eout;
        int         cnt;
        logic       ovf;
    } vec_t;

    vec_t vq[$];
    int   n_total = 0;
    int   n_pass  = 0;

    function automatic void add(logic rst, logic push, logic pop, logic clr, logic [7:0] din,
                                logic [2:0] ein, logic [7:0] dout, logic [2:0] eout, int cnt, logic ovf);
        vec_t v;
        v.rst = rst; v.push = push; v.pop = pop; v.clr = clr; v.din = din; v.ein = ein;
        v.dout = dout; v.eout = eout; v.cnt = cnt; v.ovf = ovf;
        vq.push_back(v);
    endfunction

    task automatic chk(string tag, int idx, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s #%0d: got %0h want %0h", tag, idx, act, exp);
    endtask

    task automatic chk_all(string tag, int idx, logic [7:0] dout, logic [2:0] eout, int cnt, logic ovf);
        chk({tag, " Data_Out"},      idx, 32'(Data_Out),      32'(dout));
        chk({tag, " Rx_Error"},      idx, 32'(Rx_Error),      32'(eout));
        chk({tag, " Count"},         idx, 32'(Count),         32'(cnt));
        chk({tag, " FIFO_Empty"},    idx, 32'(FIFO_Empty),    32'(cnt == 0));
        chk({tag, " Data_Rdy"},      idx, 32'(Data_Rdy),      32'(cnt != 0));
        chk({tag, " FIFO_Full"},     idx, 32'(FIFO_Full),     32'(cnt >= 5));
        chk({tag, " RTS"},           idx, 32'(RTS),           32'(cnt < 5));
        chk({tag, " FIFO_Overflow"}, idx, 32'(FIFO_Overflow), 32'(ovf));
    endtask

    task automatic drive(logic rst, logic push, logic pop, logic clr, logic [7:0] din, logic [2:0] ein);
        @(negedge Clk);
        Rst = rst; Push = push; Pop_Data = pop; Overflow_Clr = clr;
        Push_Data = din; Push_Error = ein;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        // Reset, single push/pop of 0x3C.
        add(1, 0, 0, 0, 8'h00, 3'b000, 8'h00, 3'b000, 0, 0);
        add(0, 1, 0, 0, 8'h3C, 3'b000, 8'h00, 3'b000, 1, 0);
        add(0, 0, 1, 0, 8'h00, 3'b000, 8'h3C, 3'b000, 0, 0);
        // Fill 0x00..0x07, drain in order; Full/RTS edges at 5 and 4.
        for (int i = 0; i < 8; i++) add(0, 1, 0, 0, 8'(i), 3'b000, 8'h3C, 3'b000, i + 1, 0);
        for (int i = 0; i < 8; i++) add(0, 0, 1, 0, 8'h00, 3'b000, 8'(i), 3'b000, 7 - i, 0);
        // Fill 0x20..0x27, overflow with 0xFF, drop+clear together, then clear alone.
        for (int i = 0; i < 8; i++) add(0, 1, 0, 0, 8'(32 + i), 3'(i), 8'h07, 3'b000, i + 1, 0);
        add(0, 1, 0, 0, 8'hFF, 3'b111, 8'h07, 3'b000, 8, 1);
        add(0, 1, 0, 1, 8'hFF, 3'b111, 8'h07, 3'b000, 8, 1);
        add(0, 0, 0, 1, 8'h00, 3'b000, 8'h07, 3'b000, 8, 0);
        for (int i = 0; i < 8; i++) add(0, 0, 1, 0, 8'h00, 3'b000, 8'(32 + i), 3'(i), 7 - i, 0);
        // Error status tracking and pop while empty.
        add(0, 1, 0, 0, 8'hAA, 3'b010, 8'h27, 3'b111, 1, 0);
        add(0, 1, 0, 0, 8'h00, 3'b001, 8'h27, 3'b111, 2, 0);
        add(0, 0, 1, 0, 8'h00, 3'b000, 8'hAA, 3'b010, 1, 0);
        add(0, 0, 1, 0, 8'h00, 3'b000, 8'h00, 3'b001, 0, 0);
        add(0, 0, 1, 0, 8'h00, 3'b000, 8'h00, 3'b001, 0, 0);
        // Push and pop together while empty: push wins, no write-through.
        add(0, 1, 1, 0, 8'h77, 3'b100, 8'h00, 3'b001, 1, 0);
        add(0, 0, 1, 0, 8'h00, 3'b000, 8'h77, 3'b100, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].push, vq[i].pop, vq[i].clr, vq[i].din, vq[i].ein);
            chk_all("vec", i, vq[i].dout, vq[i].eout, vq[i].cnt, vq[i].ovf);
        end

        // Full buffer with simultaneous push and pop: old head out, count stays 8, no overflow.
        for (int i = 0; i < 8; i++) drive(0, 1, 0, 0, 8'(64 + i), 3'(i));
        chk_all("fill8", 0, 8'h77, 3'b100, 8, 0);
        drive(0, 1, 1, 0, 8'hAB, 3'b011);
        chk_all("fullpp", 0, 8'h40, 3'b000, 8, 0);
        for (int i = 1; i < 8; i++) begin
            drive(0, 0, 1, 0, 8'h00, 3'b000);
            chk_all("fulldrain", i, 8'(64 + i), 3'(i), 8 - i, 0);
        end
        drive(0, 0, 1, 0, 8'h00, 3'b000);
        chk_all("fulllast", 0, 8'hAB, 3'b011, 0, 0);

        // Mid-operation reset with competing push/pop/clear, then pointer restart.
        for (int i = 0; i < 6; i++) drive(0, 1, 0, 0, 8'(16 + i), 3'b000);
        drive(0, 0, 1, 0, 8'h00, 3'b000);
        drive(0, 0, 1, 0, 8'h00, 3'b000);
        chk_all("prerst", 0, 8'h11, 3'b000, 4, 0);
        drive(1, 1, 1, 1, 8'hEE, 3'b111);
        chk_all("rst", 0, 8'h00, 3'b000, 0, 0);
        drive(0, 1, 0, 0, 8'h5A, 3'b000);
        chk_all("post_push", 0, 8'h00, 3'b000, 1, 0);
        drive(0, 0, 1, 0, 8'h00, 3'b000);
        chk_all("post_pop", 0, 8'h5A, 3'b000, 0, 0);

        drive(0, 0, 0, 0, 8'h00, 3'b000);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
